dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder for the pipelined CPU's M stage. It is the memory end of the load/store interface that the CPU drives as initiator.
- Accepts one request at a time over a valid/ready handshake and applies a fixed, configurable access latency, so the CPU's stall logic can be exercised against a non-ideal memory.
- Performs byte-lane-masked writes and full-word reads.
- Flags misaligned or out-of-range accesses instead of corrupting memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; legal byte addresses are 0 to DEPTH_WORDS*4-1.
- LATENCY, 2: extra wait cycles between the accept edge and the response; 0 is legal.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets the block.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_be  input  4  byte enables; bit i selects byte i, i.e. bits [8i+7:8i].
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, already lane-aligned.
- req_pc  input  32  PC of the issuing instruction; used only for the write log.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  access rejected; qualified by rsp_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - All memory words cleared to 0.
  - An in-flight request is dropped with no response and no write.
- States:
  - IDLE: req_ready=1. When req_valid=1, the request is captured on that edge (accept edge). Next state is WAIT if LATENCY>0, otherwise RESP.
  - WAIT: req_ready=0. Counter increments each cycle. After LATENCY WAIT cycles, next state is RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly one cycle. Next state is always IDLE.
- Timing:
  - rsp_valid is high in cycle accept+LATENCY+1.
  - No back-to-back accept: the earliest next accept is the cycle after RESP.
  - Throughput is one request per LATENCY+2 cycles.
- Request inputs are sampled only at the accept edge. Later changes are ignored.
- Legality check, evaluated on the captured request:
  - Legal byte enables are 1111 with addr[1:0]=00; 0011 or 1100 with addr[0]=0; or a single bit with the set bit equal to addr[1:0].
  - Any other pattern, be=0000, or addr >= DEPTH_WORDS*4 is illegal.
  - Illegal request: rsp_err=1, rsp_rdata=0, no memory change.
- Store: word index addr[31:2]. The enabled bytes are written on the edge that enters RESP; other bytes are preserved. rsp_rdata=0.
- Load: rsp_rdata is the full word at addr[31:2] as it stands in RESP. Byte enables only affect the legality check. The CPU performs lane extraction.
- No backpressure on the response: the initiator must hold its pipeline stalled until rsp_valid.
- rsp_rdata and rsp_err hold their last values outside RESP; only rsp_valid qualifies them.
- req_valid asserted during WAIT or RESP is ignored and not queued.

Optional Feature:
- Macro: DM_WRITE_LOG_EN.
- Defined: each legal store prints "$time@<req_pc hex>: *<word-aligned addr hex> <= <merged word hex>" at the commit edge, in the team's standard grader trace format. Errors print nothing.
- Undefined: no display statements are compiled; behaviour is otherwise identical.

Decomposition:
- Package dm_pkg:
  - state encoding constants ST_IDLE, ST_WAIT, ST_RESP.
  - byte-enable constants BE_WORD=4'b1111, BE_HALF_LO=4'b0011, BE_HALF_HI=4'b1100.
  - Default DEPTH_WORDS.
- One sub-module, dm_word_array:
  - synchronous byte-masked write port and combinational read port on word index.
  - asynchronous active-low clear.
  - Instantiated once; dm_responder holds the FSM, counter, capture registers and legality check.

Test Plan:
- Reset then store: addr=0x10, be=1111, wdata=0xDEADBEEF, LATENCY=2. Expect req_ready low 3 cycles and rsp_valid in cycle accept+3 with rsp_err=0. A following load from 0x10 returns 0xDEADBEEF.
- Byte merge: word 0x10 holds 0xDEADBEEF. Store addr=0x12, be=0100, wdata=0x00AA0000; a load from 0x10 then returns 0xDEAABEEF.
- Errors: store addr=0x11, be=0011 -> rsp_err=1 and memory unchanged. Load addr=DEPTH_WORDS*4 -> rsp_err=1, rsp_rdata=0.
- LATENCY=0 build: back-to-back req_valid=1 -> accepts every 2nd cycle, each rsp_valid one cycle after its accept; req_valid held during RESP creates no extra response.
- Reset mid-operation: reset=0 during WAIT of a store to 0x20 -> no rsp_valid, state IDLE, req_ready=1 immediately. A later load from 0x20 returns 0.
- With DM_WRITE_LOG_EN: store pc=0x00003008, addr=0x4, be=1111, wdata=0x12345678 -> exactly one log line "…@00003008: *00000004 <= 12345678"; an erroneous store logs nothing.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    localparam int DM_DEPTH_WORDS = 1024;

    // Byte-enable pattern must match the alignment implied by the low address bits.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] lsb);
        logic ok;
        case (be)
            BE_WORD:                            ok = (lsb == 2'b00);
            BE_HALF_LO, BE_HALF_HI:             ok = ~lsb[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = (be == (4'b0001 << lsb));
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_word_array.sv
// Word-organised storage: byte-masked synchronous write, combinational read,
// asynchronous active-low clear of every word.
module dm_word_array
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder with fixed access latency for the CPU M stage.
// Optional store trace is compiled in when DM_WRITE_LOG_EN is defined.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam int          CW         = $clog2(LATENCY + 1) + 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;

    logic          w_accept;
    logic          w_last_wait;
    logic          w_enter_resp;
    logic          w_cur_we;
    logic [3:0]    w_cur_be;
    logic [31:0]   w_cur_addr;
    logic [31:0]   w_cur_wdata;
    logic          w_legal;
    logic          w_wr_en;
    logic [31:0]   w_rdata;

    assign w_accept     = (r_state == ST_IDLE) && req_valid;
    assign w_last_wait  = (r_cnt == CW'(LATENCY - 1));
    assign w_enter_resp = (w_accept && (LATENCY == 0)) ||
                          ((r_state == ST_WAIT) && w_last_wait);

    // With zero latency the accept edge is also the commit edge, so the live
    // request stands in for the not-yet-loaded capture registers.
    assign w_cur_we    = (r_state == ST_IDLE) ? req_we    : r_we;
    assign w_cur_be    = (r_state == ST_IDLE) ? req_be    : r_be;
    assign w_cur_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

    assign w_legal = be_legal(w_cur_be, w_cur_addr[1:0]) &&
                     ({1'b0, w_cur_addr} < ADDR_LIMIT);
    assign w_wr_en = w_enter_resp && w_cur_we && w_legal;

    dm_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_wr_en),
        .i_be    (w_cur_be),
        .i_idx   (w_cur_addr[AW+1:2]),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (w_enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= ~w_legal;
                rsp_rdata <= (w_legal && !w_cur_we) ? w_rdata : '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_be      <= req_be;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_cnt     <= '0;
                        req_ready <= 1'b0;
                        r_state   <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last_wait) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DM_WRITE_LOG_EN
    logic [31:0] r_pc;
    logic [31:0] w_cur_pc;
    logic [31:0] w_merged;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (w_accept) begin
            r_pc <= req_pc;
        end
    end

    assign w_cur_pc = (r_state == ST_IDLE) ? req_pc : r_pc;

    always_comb begin
        w_merged = w_rdata;
        for (int b = 0; b < 4; b++) begin
            if (w_cur_be[b]) begin
                w_merged[8*b +: 8] = w_cur_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_wr_en) begin
            $display("%0t@%08h: *%08h <= %08h", $time, w_cur_pc,
                     {w_cur_addr[31:2], 2'b00}, w_merged);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed table, randomized traffic
// against a reference model, reset abort and a zero-latency instance.
module tb_dm_responder;

    localparam int DEPTH  = 1024;
    localparam int LAT    = 2;
    localparam int DEPTH0 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_we0;
    logic [3:0]  req_be0;
    logic [31:0] req_addr0, req_wdata0, req_pc0;
    logic        rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    dm_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_be(req_be0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .req_pc(req_pc0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mdl [DEPTH];

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [3:0] be, input logic [31:0] addr);
        if (64'(addr) >= 64'(DEPTH) * 4) return 1'b0;
        if (be == 4'hF) return (addr % 4) == 0;
        if (be == 4'h3 || be == 4'hC) return (addr % 2) == 0;
        if ($countones(be) == 1) return be[addr % 4] == 1'b1;
        return 1'b0;
    endfunction

    task automatic ref_apply(input bit we, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wdata, output bit exp_err,
                             output logic [31:0] exp_rdata);
        bit ok;
        int idx;
        ok        = ref_legal(be, addr);
        idx       = int'(addr / 4);
        exp_err   = !ok;
        exp_rdata = 32'h0;
        if (ok && !we) exp_rdata = mdl[idx];
        if (ok && we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
        end
    endtask

    // One request on the LATENCY=2 instance; junk is kept on the bus during the wait.
    task automatic xact(input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc,
                        output logic [31:0] rdata, output logic err, output int lat);
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        @(negedge clk);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_be = be;
        req_addr = addr; req_wdata = wdata; req_pc = pc;
        @(posedge clk);
        #1;
        req_we = 1'($urandom); req_be = 4'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
        for (int n = 1; n <= LAT + 10; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat   = n;
                rdata = rsp_rdata;
                err   = rsp_err;
                check("ready_in_resp", {31'd0, req_ready}, 32'd0);
                req_valid = 1'b0;
                break;
            end
            check("ready_in_wait", {31'd0, req_ready}, 32'd0);
        end
        if (lat < 0) req_valid = 1'b0;
        @(negedge clk);
        check("ready_after_resp", {31'd0, req_ready}, 32'd1);
        check("no_extra_rsp", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic load0(input logic [31:0] addr, input logic exp_err, input logic [31:0] exp);
        @(negedge clk);
        req_valid0 = 1'b1; req_we0 = 1'b0; req_be0 = 4'hF; req_addr0 = addr;
        @(negedge clk);
        req_valid0 = 1'b0;
        check("l0_rsp_valid", {31'd0, rsp_valid0}, 32'd1);
        check("l0_err", {31'd0, rsp_err0}, {31'd0, exp_err});
        check("l0_rdata", rsp_rdata0, exp);
        @(negedge clk);
        check("l0_rsp_done", {31'd0, rsp_valid0}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er;
        bit          exp_er;
        int          lat;

        vecs[0]  = '{1'b1, 4'b1111, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'b1111, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'b0100, 32'h12,  32'h00AA0000, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'b1111, 32'h10,  32'h0,        1'b0, 32'hDEAABEEF};
        vecs[4]  = '{1'b1, 4'b0011, 32'h11,  32'h11112222, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 4'b1111, 32'h10,  32'h0,        1'b0, 32'hDEAABEEF};
        vecs[6]  = '{1'b0, 4'b1111, 32'd4096, 32'h0,       1'b1, 32'h0};
        vecs[7]  = '{1'b0, 4'b0000, 32'h10,  32'h0,        1'b1, 32'h0};
        vecs[8]  = '{1'b1, 4'b1100, 32'h14,  32'h55660000, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 4'b0011, 32'h16,  32'h0,        1'b0, 32'h55660000};
        vecs[10] = '{1'b1, 4'b1000, 32'h17,  32'h99000000, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 4'b1000, 32'h14,  32'h0,        1'b1, 32'h0};
        vecs[12] = '{1'b0, 4'b1111, 32'h14,  32'h0,        1'b0, 32'h99660000};
        vecs[13] = '{1'b1, 4'b1111, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 4'b1111, 32'hFFC, 32'h0,        1'b0, 32'hCAFEF00D};
        vecs[15] = '{1'b0, 4'b0001, 32'h13,  32'h0,        1'b1, 32'h0};

        req_valid = 0; req_we = 0; req_be = 0; req_addr = 0; req_wdata = 0; req_pc = 0;
        req_valid0 = 0; req_we0 = 0; req_be0 = 0; req_addr0 = 0; req_wdata0 = 0; req_pc0 = 0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;

        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_ready0", {31'd0, req_ready0}, 32'd1);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            xact(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, 32'h3000 + 32'(i), rd, er, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT + 1));
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            ref_apply(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, exp_er, exp_rd);
        end

        for (int i = 0; i < 60; i++) begin
            bit          we;
            logic [3:0]  be;
            logic [31:0] addr, wdata;
            we    = 1'($urandom);
            be    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            addr  = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 40));
            wdata = $urandom;
            xact(we, be, addr, wdata, $urandom, rd, er, lat);
            ref_apply(we, be, addr, wdata, exp_er, exp_rd);
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(LAT + 1));
            check($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, exp_er});
            check($sformatf("rnd%0d_rdata", i), rd, exp_rd);
        end

        // Abort a store in its wait phase with reset.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("abort_hold_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            check("abort_post_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        xact(1'b0, 4'hF, 32'h20, 32'h0, 32'h0, rd, er, lat);
        check("abort_load_rdata", rd, 32'h0);
        check("abort_load_err", {31'd0, er}, 32'd0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 32'h0, rd, er, lat);
        check("cleared_word10", rd, 32'h0);

        // Zero-latency instance with req_valid held high every cycle.
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check($sformatf("l0_pulse_%0d", n), {31'd0, rsp_valid0}, 32'(n % 2));
            check($sformatf("l0_ready_%0d", n), {31'd0, req_ready0}, 32'((n + 1) % 2));
            req_valid0 = 1'b1; req_we0 = 1'b1; req_be0 = 4'hF;
            req_addr0 = 32'(4 * n); req_wdata0 = 32'hA0000000 + 32'(n);
        end
        @(negedge clk);
        check("l0_no_extra", {31'd0, rsp_valid0}, 32'd0);
        req_valid0 = 1'b0;
        for (int w = 0; w < 8; w++)
            load0(32'(4 * w), 1'b0, (w % 2 == 0) ? 32'hA0000000 + 32'(w) : 32'h0);
        load0(32'(DEPTH0 * 4), 1'b1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
